// File: rtl/outerprodrc_ctrl.sv
// outerprodrc_ctrl
// Sequencing controller for the unary outer-product GEMM array. A job is a
// set of output tiles (row tile, col tile). Each output tile is built from
// KTiles hidden-dimension chunks. For every chunk the controller clears the
// array, runs it for one unary stream of 2^BITWIDTH cycles, and waits LAT
// cycles for the array output to settle. It then strobes the downstream
// accumulator. Finished tiles leave through a valid/ready handshake.
//
// Ports
//   iClk, iRst                : clock, asynchronous active-high reset
//   iStart, iAbort            : job start (sampled in IDLE) and synchronous abort
//   iRowTiles/iColTiles/iKTiles : job dimensions, latched when a start is accepted
//   iReady                    : downstream accepts the finished tile
//   oClr, oEn, oCnt           : array clear strobe, run enable, stream cycle index
//   oRowTile/oColTile/oKTile  : current operand-buffer tile indices
//   oAcc, oAccFirst           : accumulate strobe, and load-instead-of-add (k == 0)
//   oValid                    : finished output tile available
//   oBusy, oDone              : job in progress, one-cycle end-of-job pulse
//
// Every output is a register. Each output is written together with the state
// transition that implies it, so no path exists from an input to an output
// without passing through a flop.
module outerprodrc_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int LAT      = 2,
  parameter int TW       = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [TW-1:0]       iRowTiles,
  input  logic [TW-1:0]       iColTiles,
  input  logic [TW-1:0]       iKTiles,
  input  logic                iReady,
  output logic                oClr,
  output logic                oEn,
  output logic [BITWIDTH-1:0] oCnt,
  output logic [TW-1:0]       oRowTile,
  output logic [TW-1:0]       oColTile,
  output logic [TW-1:0]       oKTile,
  output logic                oAcc,
  output logic                oAccFirst,
  output logic                oValid,
  output logic                oBusy,
  output logic                oDone
);

  // The drain counter only needs to reach LAT-1. It keeps at least one bit so
  // that the design still elaborates when LAT is 0 (DRAIN is then skipped).
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0]       DRAIN_LAST = DW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [BITWIDTH-1:0] CNT_LAST   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_DRAIN, S_ACC, S_OUT, S_DONE
  } state_t;

  state_t              r_state;
  logic [TW-1:0]       r_rowTiles, r_colTiles, r_kTiles;
  logic [TW-1:0]       r_row, r_col, r_k;
  logic [BITWIDTH-1:0] r_cnt;
  logic [DW-1:0]       r_dcnt;
  logic                r_clr, r_en, r_acc, r_accFirst, r_valid, r_busy, r_done;

  logic w_anyZero, w_kLast, w_colLast, w_rowLast;

  // The latched counts are nonzero whenever these are used, so subtracting
  // one cannot underflow.
  assign w_anyZero = (iRowTiles == '0) || (iColTiles == '0) || (iKTiles == '0);
  assign w_kLast   = (r_k   == r_kTiles   - 1'b1);
  assign w_colLast = (r_col == r_colTiles - 1'b1);
  assign w_rowLast = (r_row == r_rowTiles - 1'b1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_rowTiles <= '0;
      r_colTiles <= '0;
      r_kTiles   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      r_clr      <= 1'b0;
      r_en       <= 1'b0;
      r_acc      <= 1'b0;
      r_accFirst <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      r_clr      <= 1'b0;
      r_acc      <= 1'b0;
      r_accFirst <= 1'b0;
      r_done     <= 1'b0;
      if (iAbort) begin
        r_state <= S_IDLE;
        r_en    <= 1'b0;
        r_cnt   <= '0;
        r_dcnt  <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
        r_k     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (iStart) begin
              r_rowTiles <= iRowTiles;
              r_colTiles <= iColTiles;
              r_kTiles   <= iKTiles;
              r_row      <= '0;
              r_col      <= '0;
              r_k        <= '0;
              r_busy     <= 1'b1;
              if (w_anyZero) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_CLR;
                r_clr   <= 1'b1;
              end
            end
          end
          S_CLR: begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
            r_cnt   <= '0;
          end
          S_RUN: begin
            if (r_cnt == CNT_LAST) begin
              r_en  <= 1'b0;
              r_cnt <= '0;
              if (LAT == 0) begin
                r_state    <= S_ACC;
                r_acc      <= 1'b1;
                r_accFirst <= (r_k == '0);
              end else begin
                r_state <= S_DRAIN;
                r_dcnt  <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_dcnt == DRAIN_LAST) begin
              r_state    <= S_ACC;
              r_acc      <= 1'b1;
              r_accFirst <= (r_k == '0);
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
          S_ACC: begin
            if (!w_kLast) begin
              r_k     <= r_k + 1'b1;
              r_state <= S_CLR;
              r_clr   <= 1'b1;
            end else begin
              r_state <= S_OUT;
              r_valid <= 1'b1;
            end
          end
          S_OUT: begin
            if (iReady) begin
              r_valid <= 1'b0;
              r_k     <= '0;
              if (w_rowLast && w_colLast) begin
                // Indices are held for the DONE cycle and cleared on return to IDLE.
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                if (w_colLast) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
                r_state <= S_CLR;
                r_clr   <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
          end
          default: begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oClr      = r_clr;
  assign oEn       = r_en;
  assign oCnt      = r_cnt;
  assign oRowTile  = r_row;
  assign oColTile  = r_col;
  assign oKTile    = r_k;
  assign oAcc      = r_acc;
  assign oAccFirst = r_accFirst;
  assign oValid    = r_valid;
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule
